// File: rtl/led7seg_scan4.sv
// Four-digit multiplexed seven-segment scanner with blanking gaps and frame-aligned value commit.
// Optional leading-zero suppression is enabled by defining LED7SEG_ZBLANK_EN.
module led7seg_scan4 #(
  parameter int DIV       = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DATA,
  input  logic [3:0]  DP,
  input  logic        LOAD,
  output logic        ACK,
  output logic [7:0]  LED,
  output logic [3:0]  SA
);

  localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [1:0]    idx_reg;
  logic [15:0]   act_data_reg, pend_data_reg;
  logic [3:0]    act_dp_reg, pend_dp_reg;
  logic          pend_valid_reg;

  logic          end_cnt, wrap, commit;
  logic [1:0]    tgt_idx;
  logic [15:0]   tgt_data;
  logic [3:0]    tgt_dp;
  logic [3:0]    nib;
  logic [6:0]    seg;
  logic          hide;
  logic [7:0]    show_led;
  logic [3:0]    show_sa;

  assign end_cnt = (cnt_reg <= CW'(1));
  assign wrap    = (state_reg == SHOW) && end_cnt && (idx_reg == 2'd3);
  assign commit  = wrap && pend_valid_reg;

  // The next lit digit: the following one when leaving SHOW, otherwise the current one.
  // Its data must already reflect a commit happening on the same edge.
  always_comb begin
    tgt_idx  = (state_reg == SHOW) ? idx_reg + 2'd1 : idx_reg;
    tgt_data = commit ? pend_data_reg : act_data_reg;
    tgt_dp   = commit ? pend_dp_reg : act_dp_reg;
    nib      = tgt_data[{tgt_idx, 2'b00} +: 4];
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    hide = 1'b0;
`ifdef LED7SEG_ZBLANK_EN
    case (tgt_idx)
      2'd3:    hide = (tgt_data[15:12] == 4'h0) && (tgt_dp[3] == 1'b0);
      2'd2:    hide = (tgt_data[15:8] == 8'h00) && (tgt_dp[3:2] == 2'b00);
      2'd1:    hide = (tgt_data[15:4] == 12'h000) && (tgt_dp[3:1] == 3'b000);
      default: hide = 1'b0;
    endcase
`endif
    if (hide) begin
      show_led = 8'hFF;
      show_sa  = 4'hF;
    end else begin
      show_led = {~tgt_dp[tgt_idx], seg};
      show_sa  = ~(4'b0001 << tgt_idx);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= BLANK;
      cnt_reg        <= CW'(BLANK_CYC);
      idx_reg        <= 2'd0;
      act_data_reg   <= 16'h0000;
      act_dp_reg     <= 4'h0;
      pend_data_reg  <= 16'h0000;
      pend_dp_reg    <= 4'h0;
      pend_valid_reg <= 1'b0;
      ACK            <= 1'b0;
      LED            <= 8'hFF;
      SA             <= 4'hF;
    end else begin
      ACK <= 1'b0;
      // Commit reads the old pending contents; a coincident LOAD refills it afterwards.
      if (commit) begin
        act_data_reg   <= pend_data_reg;
        act_dp_reg     <= pend_dp_reg;
        pend_valid_reg <= 1'b0;
        ACK            <= 1'b1;
      end
      if (LOAD) begin
        pend_data_reg  <= DATA;
        pend_dp_reg    <= DP;
        pend_valid_reg <= 1'b1;
      end
      case (state_reg)
        BLANK: begin
          if (end_cnt) begin
            state_reg <= SHOW;
            cnt_reg   <= CW'(DIV);
            LED       <= show_led;
            SA        <= show_sa;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        default: begin
          if (end_cnt) begin
            idx_reg <= idx_reg + 2'd1;
            if (BLANK_CYC == 0) begin
              cnt_reg <= CW'(DIV);
              LED     <= show_led;
              SA      <= show_sa;
            end else begin
              state_reg <= BLANK;
              cnt_reg   <= CW'(BLANK_CYC);
              LED       <= 8'hFF;
              SA        <= 4'hF;
            end
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led7seg_scan4.sv
// Randomised bench for led7seg_scan4 (DIV=4, BLANK_CYC=2) against a time-slot reference model.
// Define LED7SEG_ZBLANK_EN for both bench and RTL to exercise leading-zero suppression.
module tb_led7seg_scan4;

  localparam int DIV   = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = DIV + BLANK;
  localparam int FRAME = 4 * SLOT;

  logic        CLK, RST, LOAD, ACK;
  logic [15:0] DATA;
  logic [3:0]  DP, SA;
  logic [7:0]  LED;

  led7seg_scan4 #(.DIV(DIV), .BLANK_CYC(BLANK)) dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .DP(DP), .LOAD(LOAD),
    .ACK(ACK), .LED(LED), .SA(SA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hex decode table, g..a active-low.
  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int          n_cmp, n_err, acks_seen;
  int          m_t;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic        m_pv, m_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, m_t);
    end
  endtask

  // Expected display outputs from elapsed cycles since reset and the displayed value.
  task automatic expect_outputs(output logic [3:0] e_sa, output logic [7:0] e_led);
    int q, d;
    logic [3:0] nib;
    logic dpb;
    bit hide;
    q = m_t % SLOT;
    d = (m_t % FRAME) / SLOT;
    e_sa  = 4'hF;
    e_led = 8'hFF;
    if (q >= BLANK) begin
      nib  = 4'((m_act >> (4 * d)) & 16'hF);
      dpb  = m_act_dp[d];
      hide = 1'b0;
`ifdef LED7SEG_ZBLANK_EN
      if (d > 0 && (m_act >> (4 * d)) == 16'h0 && (m_act_dp >> d) == 4'h0) hide = 1'b1;
`endif
      if (!hide) begin
        e_sa  = 4'(15 - (1 << d));
        e_led = {~dpb, seg_tab[nib]};
      end
    end
  endtask

  task automatic step(input logic rst, input logic load, input logic [15:0] d, input logic [3:0] p);
    logic [3:0] e_sa;
    logic [7:0] e_led;
    RST = rst; LOAD = load; DATA = d; DP = p;
    @(posedge CLK);
    if (rst) begin
      m_t = 0; m_act = 0; m_act_dp = 0; m_pend = 0; m_pend_dp = 0; m_pv = 0; m_ack = 0;
    end else begin
      m_t++;
      m_ack = 1'b0;
      if (m_t % FRAME == 0 && m_pv) begin
        m_act = m_pend; m_act_dp = m_pend_dp; m_pv = 1'b0; m_ack = 1'b1;
      end
      if (load) begin
        m_pend = d; m_pend_dp = p; m_pv = 1'b1;
      end
    end
    #1;
    expect_outputs(e_sa, e_led);
    check("ack", ACK, m_ack);
    check("sa", SA, e_sa);
    check("led", LED, e_led);
    if (ACK === 1'b1) begin
      acks_seen++;
      $display("ack t=%0d active=%04h dp=%b", m_t, m_act, m_act_dp);
    end
    if (load) $display("load t=%0d data=%04h dp=%b", m_t, d, p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic idle_until(input int phase, input string tag);
    int g;
    g = 0;
    while (m_t % FRAME != phase && g < FRAME + 2) begin
      idle(1);
      g++;
    end
    check(tag, 32'(m_t % FRAME), 32'(phase));
  endtask

  initial begin
    int lat, base;
    logic [15:0] rd;
    logic [15:0] masks [4] = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0000};
    n_cmp = 0; n_err = 0; acks_seen = 0;
    m_t = 0; m_act = 0; m_act_dp = 0; m_pend = 0; m_pend_dp = 0; m_pv = 0; m_ack = 0;
    RST = 1'b1; LOAD = 1'b0; DATA = 16'h0; DP = 4'h0;

    // Reset held three cycles, then first digit after two cycles.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'($urandom), 4'($urandom));
    idle(2);
    check("first_sa", SA, 4'b1110);

    // Scan 1280 with ACK latency bound.
    step(1'b0, 1'b1, 16'h1280, 4'b0000);
    lat = 1;
    while (ACK !== 1'b1 && lat < 30) begin
      idle(1);
      lat++;
    end
    check("scan_lat_ok", 32'(lat <= 24), 32'd1);
    idle(FRAME);

    // Last LOAD wins: one ACK, display 2222.
    idle_until(3, "hs_align");
    base = acks_seen;
    step(1'b0, 1'b1, 16'h1111, 4'b0000);
    idle(2);
    step(1'b0, 1'b1, 16'h2222, 4'b0000);
    idle(FRAME);
    check("hs_one_ack", 32'(acks_seen - base), 32'd1);
    check("hs_active", m_act, 16'h2222);

    // LOAD on the wrap edge: old pending commits now, new one a frame later.
    idle_until(5, "wrap_align_a");
    base = acks_seen;
    step(1'b0, 1'b1, 16'hABCD, 4'b1010);
    idle_until(FRAME - 1, "wrap_align_b");
    step(1'b0, 1'b1, 16'h3E7F, 4'b0101);
    check("wrap_ack_now", ACK, 1'b1);
    idle(FRAME + 2);
    check("wrap_two_acks", 32'(acks_seen - base), 32'd2);

    // Decimal point on digit 0, then leading-zero pattern.
    step(1'b0, 1'b1, 16'h0005, 4'b0001);
    idle(2 * FRAME);
    step(1'b0, 1'b1, 16'h0005, 4'b0000);
    idle(2 * FRAME);

    // Mid-frame reset during digit 2 SHOW with a pending value.
    idle_until(8, "mr_align_a");
    step(1'b0, 1'b1, 16'h9876, 4'b1111);
    idle_until(15, "mr_align_b");
    step(1'b1, 1'b0, 16'($urandom), 4'($urandom));
    base = acks_seen;
    idle(2 * FRAME);
    check("mr_no_ack", 32'(acks_seen - base), 32'd0);
    check("mr_active", m_act, 16'h0000);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      rd = 16'($urandom) & masks[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) step(1'b0, 1'b1, rd, 4'($urandom_range(0, 15) & 4'($urandom)));
      else if ($urandom_range(0, 199) == 0) step(1'b1, 1'b0, rd, 4'($urandom));
      else step(1'b0, 1'b0, rd, 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
